// File: rtl/cdr_acq_ctrl_if.sv
// Symbol-rate bus between the MM-PD / slicer front end and the CDR acquisition
// sequencer, plus the gain/clear/lock outputs fed back to the loop filter.
//
// Handshake: sample_en is the only qualifier. f_n and d_bb are consumed on any
// clk edge where sample_en is high. There is no back-pressure. All outputs are
// level signals except lol_pulse, which is a one-clk strobe.
interface cdr_acq_ctrl_if;
    logic               en;
    logic               sample_en;
    logic signed [15:0] f_n;
    logic               d_bb;
    logic [4:0]         kp_shift;
    logic [4:0]         ki_shift;
    logic               loop_clr;
    logic               locked;
    logic               lol_pulse;
    logic [2:0]         state;
    logic [7:0]         retry_cnt;

    modport master (
        output en, sample_en, f_n, d_bb,
        input  kp_shift, ki_shift, loop_clr, locked, lol_pulse, state, retry_cnt
    );

    modport slave (
        input  en, sample_en, f_n, d_bb,
        output kp_shift, ki_shift, loop_clr, locked, lol_pulse, state, retry_cnt
    );
endinterface

// File: rtl/cdr_acq_ctrl.sv
// Acquisition/lock sequencer for the baud-rate MM-PD CDR loop. It steps the
// loop filter through flush, wide-gain acquisition and narrow-gain tracking.
// It judges lock from windowed |f_n| energy and decision transition density.
// It drops back to FLUSH on loss of lock or on a tracking timeout.
module cdr_acq_ctrl #(
    parameter logic [4:0] ACQ_KP        = 5'd8,
    parameter logic [4:0] ACQ_KI        = 5'd14,
    parameter logic [4:0] TRK_KP        = 5'd12,
    parameter logic [4:0] TRK_KI        = 5'd18,
    parameter int         FLUSH_SYMS    = 16,
    parameter int         ACQ_SYMS      = 1024,
    parameter int         WIN_LOG2      = 6,
    parameter int         LOCK_THR      = 256,
    parameter int         UNLOCK_THR    = 1024,
    parameter int         MIN_TRANS     = 8,
    parameter int         LOCK_WINS     = 4,
    parameter int         UNLOCK_WINS   = 2,
    parameter int         TRACK_TIMEOUT = 32
) (
    input logic           clk,
    input logic           rst,
    cdr_acq_ctrl_if.slave bus
);
    localparam int PH_MAX  = (FLUSH_SYMS > ACQ_SYMS) ? FLUSH_SYMS : ACQ_SYMS;
    localparam int PH_W    = $clog2(PH_MAX + 1);
    localparam int RUN_MAX = (LOCK_WINS > UNLOCK_WINS) ? LOCK_WINS : UNLOCK_WINS;
    localparam int RUN_W   = $clog2(RUN_MAX + 1);
    localparam int TMO_W   = $clog2(TRACK_TIMEOUT + 1);
    localparam int TR_W    = WIN_LOG2 + 1;
    localparam logic [31:0] LOCK_THR_U   = 32'(LOCK_THR);
    localparam logic [31:0] UNLOCK_THR_U = 32'(UNLOCK_THR);
    localparam logic [31:0] MIN_TRANS_U  = 32'(MIN_TRANS);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FLUSH  = 3'd1,
        ST_ACQ    = 3'd2,
        ST_TRACK  = 3'd3,
        ST_LOCKED = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [PH_W-1:0]     ph_cnt_q, ph_cnt_d;
    logic [RUN_W-1:0]    run_q, run_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [WIN_LOG2-1:0] win_cnt_q, win_cnt_d;
    logic [23:0]         acc_q, acc_d;
    logic [TR_W-1:0]     trans_q, trans_d;
    logic                d_prev_q, d_prev_d;
    logic                have_prev_q, have_prev_d;
    logic [4:0]          kp_q, kp_d, ki_q, ki_d;
    logic                loop_clr_q, loop_clr_d;
    logic                locked_q, locked_d;
    logic                lol_q, lol_d;
    logic [7:0]          retry_q, retry_d;

    logic                strobe, win_end, quiet, noisy;
    logic                unlock_evt, retry_evt;
    logic [15:0]         f_raw, mag;
    logic [24:0]         acc_wide;
    logic [23:0]         acc_sum;
    logic [TR_W-1:0]     trans_sum;

    // Window arithmetic: |f_n| with -32768 clamped, saturating sums, end-of-window verdict
    always_comb begin
        strobe = bus.sample_en && (state_q != ST_IDLE);
        f_raw  = bus.f_n;
        if (!f_raw[15])              mag = f_raw;
        else if (f_raw == 16'h8000)  mag = 16'h7fff;
        else                         mag = ~f_raw + 16'd1;
        acc_wide = {1'b0, acc_q} + {9'd0, mag};
        acc_sum  = acc_wide[24] ? 24'hff_ffff : acc_wide[23:0];
        trans_sum = trans_q;
        if (have_prev_q && (bus.d_bb != d_prev_q) && (trans_q != {TR_W{1'b1}}))
            trans_sum = trans_q + TR_W'(1);
        win_end = strobe && (win_cnt_q == {WIN_LOG2{1'b1}});
        quiet   = (32'(acc_sum) < LOCK_THR_U) && (32'(trans_sum) >= MIN_TRANS_U);
        noisy   = (32'(acc_sum) > UNLOCK_THR_U) || (32'(trans_sum) < MIN_TRANS_U);
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // FSM next state, phase/run/timeout counters and retry/unlock events
    always_comb begin
        state_d    = state_q;
        ph_cnt_d   = ph_cnt_q;
        run_d      = run_q;
        tmo_d      = tmo_q;
        unlock_evt = 1'b0;
        retry_evt  = 1'b0;
        case (state_q)
            ST_IDLE: state_d = ST_FLUSH;
            ST_FLUSH: begin
                if (strobe) begin
                    if (ph_cnt_q == PH_W'(FLUSH_SYMS - 1)) state_d = ST_ACQ;
                    else                                   ph_cnt_d = ph_cnt_q + PH_W'(1);
                end
            end
            ST_ACQ: begin
                if (strobe) begin
                    if (ph_cnt_q == PH_W'(ACQ_SYMS - 1)) state_d = ST_TRACK;
                    else                                 ph_cnt_d = ph_cnt_q + PH_W'(1);
                end
            end
            ST_TRACK: begin
                if (win_end) begin
                    if (quiet && (run_q == RUN_W'(LOCK_WINS - 1))) begin
                        state_d = ST_LOCKED;
                    end else begin
                        run_d = quiet ? run_q + RUN_W'(1) : '0;
                        if (tmo_q == TMO_W'(TRACK_TIMEOUT - 1)) begin
                            state_d   = ST_FLUSH;
                            retry_evt = 1'b1;
                        end else begin
                            tmo_d = tmo_q + TMO_W'(1);
                        end
                    end
                end
            end
            ST_LOCKED: begin
                if (win_end) begin
                    if (!noisy) begin
                        run_d = '0;
                    end else if (run_q == RUN_W'(UNLOCK_WINS - 1)) begin
                        state_d    = ST_FLUSH;
                        unlock_evt = 1'b1;
                        retry_evt  = 1'b1;
                    end else begin
                        run_d = run_q + RUN_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Disable overrides everything and abandons any pending retry
        if (!bus.en) begin
            state_d    = ST_IDLE;
            unlock_evt = 1'b0;
            retry_evt  = 1'b0;
        end
        if (state_d != state_q) begin
            ph_cnt_d = '0;
            run_d    = '0;
            tmo_d    = '0;
        end
    end

    // Window accumulators: restart at window end, fully cleared on any state change
    always_comb begin
        win_cnt_d   = win_cnt_q;
        acc_d       = acc_q;
        trans_d     = trans_q;
        d_prev_d    = d_prev_q;
        have_prev_d = have_prev_q;
        if (state_d != state_q) begin
            win_cnt_d   = '0;
            acc_d       = '0;
            trans_d     = '0;
            d_prev_d    = 1'b0;
            have_prev_d = 1'b0;
        end else if (strobe) begin
            win_cnt_d   = win_cnt_q + WIN_LOG2'(1);
            d_prev_d    = bus.d_bb;
            have_prev_d = 1'b1;
            acc_d       = win_end ? '0 : acc_sum;
            trans_d     = win_end ? '0 : trans_sum;
        end
    end

    // Counter and window datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ph_cnt_q    <= '0;
            run_q       <= '0;
            tmo_q       <= '0;
            win_cnt_q   <= '0;
            acc_q       <= '0;
            trans_q     <= '0;
            d_prev_q    <= 1'b0;
            have_prev_q <= 1'b0;
        end else begin
            ph_cnt_q    <= ph_cnt_d;
            run_q       <= run_d;
            tmo_q       <= tmo_d;
            win_cnt_q   <= win_cnt_d;
            acc_q       <= acc_d;
            trans_q     <= trans_d;
            d_prev_q    <= d_prev_d;
            have_prev_q <= have_prev_d;
        end
    end

    // FSM outputs decoded from the next state so they land on the transition edge
    always_comb begin
        loop_clr_d = 1'b0;
        kp_d       = ACQ_KP;
        ki_d       = ACQ_KI;
        locked_d   = 1'b0;
        lol_d      = unlock_evt;
        retry_d    = retry_q;
        case (state_d)
            ST_IDLE, ST_FLUSH: loop_clr_d = 1'b1;
            ST_ACQ:            loop_clr_d = 1'b0;
            ST_TRACK: begin
                kp_d = TRK_KP;
                ki_d = TRK_KI;
            end
            ST_LOCKED: begin
                kp_d     = TRK_KP;
                ki_d     = TRK_KI;
                locked_d = 1'b1;
            end
            default: loop_clr_d = 1'b1;
        endcase
        if (retry_evt && (retry_q != 8'hff)) retry_d = retry_q + 8'd1;
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            loop_clr_q <= 1'b1;
            kp_q       <= ACQ_KP;
            ki_q       <= ACQ_KI;
            locked_q   <= 1'b0;
            lol_q      <= 1'b0;
            retry_q    <= 8'd0;
        end else begin
            loop_clr_q <= loop_clr_d;
            kp_q       <= kp_d;
            ki_q       <= ki_d;
            locked_q   <= locked_d;
            lol_q      <= lol_d;
            retry_q    <= retry_d;
        end
    end

    assign bus.kp_shift  = kp_q;
    assign bus.ki_shift  = ki_q;
    assign bus.loop_clr  = loop_clr_q;
    assign bus.locked    = locked_q;
    assign bus.lol_pulse = lol_q;
    assign bus.state     = state_q;
    assign bus.retry_cnt = retry_q;
endmodule
